// File: rtl/hp_pkg.sv
// Shared constants for the alarm monitor: register offsets, CTRL/STATUS bit
// positions, channel limit and the clear-hold state type.
package hp_pkg;

   localparam int MAX_CH = 16;

   localparam logic [31:0] OFS_CTRL   = 32'h0000_0000;
   localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
   localparam logic [31:0] OFS_CLEAR  = 32'h0000_0008;
   localparam logic [31:0] OFS_CNT0   = 32'h0000_000C;

   localparam int CTRL_EN_LSB      = 0;
   localparam int CTRL_IRQ_EN_BIT  = 16;
   localparam int STATUS_LATCH_LSB = 0;
   localparam int STATUS_BUSY_BIT  = 31;

   typedef enum logic {
      CLR_IDLE = 1'b0,
      CLR_HOLD = 1'b1
   } clr_state_t;

   function automatic logic [31:0] cnt_offset(input int ch);
      return OFS_CNT0 + 32'(4 * ch);
   endfunction

endpackage

// File: rtl/hp_alarm_chan.sv
// One alarm channel: 2-flop synchronizer, rising-edge detect, sticky latch and
// saturating event counter.
module hp_alarm_chan #(
   parameter int CTR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alarm,
   input  logic             enable,
   input  logic             clear,
   output logic             latch,
   output logic [CTR_W-1:0] count
);

   logic sync_q1;
   logic sync_q2;
   logic edge_q;
   logic evt;

   assign evt = sync_q2 & ~edge_q & enable;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         edge_q  <= 1'b0;
         latch   <= 1'b0;
         count   <= '0;
      end else begin
         sync_q1 <= alarm;
         sync_q2 <= sync_q1;
         edge_q  <= sync_q2;
         // an event landing on the clear cycle survives as the first new count
         if (clear) begin
            latch <= evt;
            count <= evt ? CTR_W'(1) : '0;
         end else if (evt) begin
            latch <= 1'b1;
            if (count != '1) begin
               count <= count + CTR_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/hp_alarm_monitor.sv
// Alarm monitor with wishbone register access and delayed channel clear.
// Define HP_ALARM_IRQ_EN to build the CTRL irq_en bit and the irq_o logic.
//
// clear-hold FSM
//   state    | meaning
//   CLR_IDLE | no clear pending
//   CLR_HOLD | pending mask held, hold_tmr counting down to terminal count
module hp_alarm_monitor
   import hp_pkg::*;
#(
   parameter int          NUM_CH       = 4,
   parameter int          CTR_W        = 8,
   parameter int          RESET_SHR    = 16,
   parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000
) (
   input  logic              wb_clk_i,
   input  logic              reset,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic              wbs_stl_o,
   output logic [31:0]       wbs_dat_o,
   input  logic [NUM_CH-1:0] alarm_i,
   output logic [NUM_CH-1:0] alarm_latch_o,
   output logic              irq_o
);

   localparam int TMR_W = $clog2(RESET_SHR);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RESET_SHR - 1);

   logic [31:0]       offset;
   logic              req;
   logic              hit;
   logic [31:0]       rdata;
   logic              ctrl_wr;
   logic              clr_wr;
   logic [NUM_CH-1:0] wr_mask;
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] latch;
   logic [NUM_CH-1:0] clr_now;
   logic [NUM_CH-1:0] pend_mask;
   logic [CTR_W-1:0]  cnt [NUM_CH];
   clr_state_t        clr_state;
   logic [TMR_W-1:0]  hold_tmr;
   logic              unused_dat;

   assign offset    = wbs_adr_i - BASE_ADDRESS;
   assign req       = wbs_cyc_i & wbs_stb_i;
   assign ctrl_wr   = req & wbs_we_i & (offset == OFS_CTRL);
   assign clr_wr    = req & wbs_we_i & (offset == OFS_CLEAR);
   assign wr_mask   = wbs_dat_i[NUM_CH-1:0];
   assign wbs_stl_o = 1'b0;
   assign unused_dat = ^wbs_dat_i;

`ifdef HP_ALARM_IRQ_EN
   logic irq_en;

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         irq_en <= 1'b0;
         irq_o  <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            irq_en <= wbs_dat_i[CTRL_IRQ_EN_BIT];
         end
         irq_o <= irq_en & (|latch);
      end
   end
`else
   assign irq_o = 1'b0;
`endif

   always_comb begin
      hit   = 1'b0;
      rdata = '0;
      if (offset == OFS_CTRL) begin
         hit = 1'b1;
         rdata[CTRL_EN_LSB +: NUM_CH] = ch_en;
`ifdef HP_ALARM_IRQ_EN
         rdata[CTRL_IRQ_EN_BIT] = irq_en;
`endif
      end else if (offset == OFS_STATUS) begin
         hit = 1'b1;
         rdata[STATUS_LATCH_LSB +: NUM_CH] = latch;
         rdata[STATUS_BUSY_BIT] = (clr_state == CLR_HOLD);
      end else if (offset == OFS_CLEAR) begin
         hit = 1'b1;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (offset == cnt_offset(i)) begin
               hit = 1'b1;
               rdata[CTR_W-1:0] = cnt[i];
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         ch_en     <= '0;
      end else begin
         wbs_ack_o <= req & hit;
         wbs_dat_o <= (req & hit & ~wbs_we_i) ? rdata : '0;
         if (ctrl_wr) begin
            ch_en <= wbs_dat_i[CTRL_EN_LSB +: NUM_CH];
         end
      end
   end

   // a CLEAR write on the terminal-count cycle restarts or cancels the hold instead
   assign clr_now = (clr_state == CLR_HOLD && !clr_wr && hold_tmr == '0) ? pend_mask : '0;

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         clr_state <= CLR_IDLE;
         pend_mask <= '0;
         hold_tmr  <= '0;
      end else begin
         case (clr_state)
            CLR_IDLE: begin
               if (clr_wr && (|wr_mask)) begin
                  pend_mask <= wr_mask;
                  hold_tmr  <= TMR_LOAD;
                  clr_state <= CLR_HOLD;
               end
            end
            CLR_HOLD: begin
               if (clr_wr) begin
                  if (|wr_mask) begin
                     pend_mask <= pend_mask | wr_mask;
                     hold_tmr  <= TMR_LOAD;
                  end else begin
                     pend_mask <= '0;
                     clr_state <= CLR_IDLE;
                  end
               end else if (hold_tmr == '0) begin
                  pend_mask <= '0;
                  clr_state <= CLR_IDLE;
               end else begin
                  hold_tmr <= hold_tmr - TMR_W'(1);
               end
            end
            default: begin
               clr_state <= CLR_IDLE;
               pend_mask <= '0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      hp_alarm_chan #(
         .CTR_W(CTR_W)
      ) u_chan (
         .clk    (wb_clk_i),
         .reset  (reset),
         .alarm  (alarm_i[g]),
         .enable (ch_en[g]),
         .clear  (clr_now[g]),
         .latch  (latch[g]),
         .count  (cnt[g])
      );
   end

   assign alarm_latch_o = latch;

endmodule

// File: tb/tb_hp_alarm_monitor.sv
// Bench for hp_alarm_monitor: directed sequence with random enables and pulse
// patterns, checked against a per-channel count/latch model.
module tb_hp_alarm_monitor;

   localparam int          NUM_CH    = 4;
   localparam int          CTR_W     = 8;
   localparam int          RESET_SHR = 16;
   localparam logic [31:0] BASE      = 32'h3000_0000;
   localparam int          CMAX      = (1 << CTR_W) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              cyc, stb, we;
   logic [31:0]       adr, wdat;
   logic              ack, stl;
   logic [31:0]       rdat;
   logic [NUM_CH-1:0] alarm;
   logic [NUM_CH-1:0] latch_o;
   logic              irq;

   int total = 0;
   int bad   = 0;

   int              m_cnt   [NUM_CH];
   bit              m_latch [NUM_CH];
   bit [NUM_CH-1:0] m_en;
   bit              m_irqen;

   hp_alarm_monitor #(
      .NUM_CH(NUM_CH), .CTR_W(CTR_W), .RESET_SHR(RESET_SHR), .BASE_ADDRESS(BASE)
   ) dut (
      .wb_clk_i      (clk),
      .reset         (reset),
      .wbs_cyc_i     (cyc),
      .wbs_stb_i     (stb),
      .wbs_we_i      (we),
      .wbs_adr_i     (adr),
      .wbs_dat_i     (wdat),
      .wbs_ack_o     (ack),
      .wbs_stl_o     (stl),
      .wbs_dat_o     (rdat),
      .alarm_i       (alarm),
      .alarm_latch_o (latch_o),
      .irq_o         (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: sim time limit reached, bench did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void m_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_cnt[i]   = 0;
         m_latch[i] = 0;
      end
      m_en    = '0;
      m_irqen = 0;
   endfunction

   function automatic void m_pulse(input logic [NUM_CH-1:0] v);
      for (int i = 0; i < NUM_CH; i++) begin
         if (v[i] && m_en[i]) begin
            m_latch[i] = 1;
            if (m_cnt[i] < CMAX) m_cnt[i]++;
         end
      end
   endfunction

   function automatic void m_clear(input logic [NUM_CH-1:0] mask);
      for (int i = 0; i < NUM_CH; i++) begin
         if (mask[i]) begin
            m_cnt[i]   = 0;
            m_latch[i] = 0;
         end
      end
   endfunction

   function automatic logic [NUM_CH-1:0] m_latch_vec();
      logic [NUM_CH-1:0] v = '0;
      for (int i = 0; i < NUM_CH; i++) v[i] = m_latch[i];
      return v;
   endfunction

   function automatic logic m_irq();
`ifdef HP_ALARM_IRQ_EN
      return m_irqen && (m_latch_vec() != '0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic wb_write(input logic [31:0] ofs, input logic [31:0] data, input bit mapped);
      cyc = 1; stb = 1; we = 1; adr = BASE + ofs; wdat = data;
      tick();
      chk("wr_ack", 32'(ack), 32'(mapped));
      chk("wr_dat", rdat, 32'h0);
      cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0;
   endtask

   task automatic wb_read(input logic [31:0] ofs, input logic [31:0] want, input string tag, input bit mapped);
      cyc = 1; stb = 1; we = 0; adr = BASE + ofs;
      tick();
      chk({tag, "_ack"}, 32'(ack), 32'(mapped));
      chk(tag, rdat, mapped ? want : 32'h0);
      cyc = 0; stb = 0; adr = 0;
   endtask

   task automatic pulse_vec(input logic [NUM_CH-1:0] v);
      alarm = v;
      tick();
      alarm = '0;
      tick();
      m_pulse(v);
   endtask

   task automatic settle();
      repeat (4) tick();
   endtask

   task automatic check_all(input string tag);
      wb_read(32'h4, 32'(m_latch_vec()), {tag, "_status"}, 1);
      for (int i = 0; i < NUM_CH; i++)
         wb_read(32'hC + 32'(4 * i), 32'(m_cnt[i]), $sformatf("%s_cnt%0d", tag, i), 1);
      chk({tag, "_latch_o"}, 32'(latch_o), 32'(m_latch_vec()));
      chk({tag, "_irq"}, 32'(irq), 32'(m_irq()));
   endtask

   function automatic logic [31:0] ctrl_readback(input logic [31:0] data);
      logic [31:0] r = data & 32'h0000_000F;
`ifdef HP_ALARM_IRQ_EN
      r[16] = data[16];
`endif
      return r;
   endfunction

   task automatic write_ctrl(input logic [31:0] data);
      wb_write(32'h0, data, 1);
      m_en    = data[NUM_CH-1:0];
      m_irqen = data[16];
   endtask

   initial begin
      logic [31:0]       d;
      logic [NUM_CH-1:0] v;
      int                n;

      reset = 1; cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; alarm = '0;
      m_reset();
      repeat (3) tick();
      chk("rst_ack", 32'(ack), 0);
      chk("rst_dat", rdat, 0);
      chk("rst_latch", 32'(latch_o), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_stall", 32'(stl), 0);
      reset = 0;
      tick();
      wb_read(32'h0, 32'h0, "rst_ctrl", 1);
      tick();
      chk("ack_one_cycle", 32'(ack), 0);
      check_all("rst");

      // single pulse latency on channel 0
      write_ctrl(32'h1);
      alarm = 4'b0001;
      tick();
      alarm = '0;
      chk("lat_edge1", 32'(latch_o[0]), 0);
      tick();
      chk("lat_edge2", 32'(latch_o[0]), 0);
      tick();
      chk("lat_edge3", 32'(latch_o[0]), 1);
      m_pulse(4'b0001);
      settle();
      check_all("single");

      // pulse on a disabled channel is ignored
      pulse_vec(4'b0010);
      settle();
      check_all("disabled");

      // random enables and pulse patterns
      for (int r = 0; r < 4; r++) begin
         d = $urandom;
         write_ctrl(d);
         wb_read(32'h0, ctrl_readback(d), "rand_ctrl", 1);
         n = $urandom_range(3, 12);
         for (int p = 0; p < n; p++) begin
            v = NUM_CH'($urandom);
            pulse_vec(v);
         end
         settle();
         check_all($sformatf("rand%0d", r));
      end

      // known state: channels 0,1 latched, 2,3 cleared
      write_ctrl(32'h0001_000F);
      pulse_vec(4'b0011);
      pulse_vec(4'b0011);
      wb_write(32'h8, 32'hC, 1);
      repeat (RESET_SHR + 2) tick();
      m_clear(4'b1100);
      check_all("prep");

      // clear timing: busy for RESET_SHR cycles, then channel 0 cleared
      wb_write(32'h8, 32'h1, 1);
      wb_read(32'h4, 32'h8000_0003, "hold_status_first", 1);
      for (int k = 0; k < RESET_SHR - 2; k++) begin
         chk("hold_latch_kept", 32'(latch_o), 32'h3);
         tick();
      end
      wb_read(32'h4, 32'h8000_0003, "hold_status_last", 1);
      chk("hold_latch_done", 32'(latch_o), 32'h2);
      m_clear(4'b0001);
      tick();
      check_all("cleared0");

      // cancelled clear
      pulse_vec(4'b0001);
      settle();
      wb_write(32'h8, 32'h1, 1);
      repeat (4) tick();
      wb_write(32'h8, 32'h0, 1);
      repeat (RESET_SHR + 4) tick();
      check_all("cancel");

      // merged clear restarts the hold from the second write
      pulse_vec(4'b0111);
      settle();
      wb_write(32'h8, 32'h1, 1);
      repeat (9) tick();
      wb_write(32'h8, 32'h2, 1);
      for (int k = 0; k < RESET_SHR - 1; k++) begin
         tick();
         chk("merge_latch_kept", 32'(latch_o), 32'(m_latch_vec()));
      end
      tick();
      m_clear(4'b0011);
      chk("merge_latch_done", 32'(latch_o), 32'(m_latch_vec()));
      check_all("merge");

      // event coinciding with clear completion
      pulse_vec(4'b0001);
      pulse_vec(4'b0001);
      settle();
      chk("coinc_pre_irq", 32'(irq), 32'(m_irq()));
      wb_write(32'h8, 32'h1, 1);
      repeat (RESET_SHR - 3) tick();
      alarm = 4'b0001;
      tick();
      alarm = '0;
      tick();
      tick();
      m_clear(4'b0001);
      m_pulse(4'b0001);
      chk("coinc_latch", 32'(latch_o), 32'(m_latch_vec()));
      settle();
      check_all("coinc");

      // clear everything: irq must drop
      wb_write(32'h8, 32'hF, 1);
      repeat (RESET_SHR + 2) tick();
      m_clear(4'b1111);
      check_all("clear_all");

      // saturation on channel 2
      for (int p = 0; p < 300; p++) pulse_vec(4'b0100);
      settle();
      check_all("sat");

      // unmapped addresses and ignored writes
      wb_read(32'h1C, 32'h0, "unmapped_cnt4", 0);
      wb_read(32'h2, 32'h0, "unmapped_misaligned", 0);
      wb_read(32'h1000_0000, 32'h0, "unmapped_far", 0);
      wb_write(32'h20, 32'hFFFF_FFFF, 0);
      wb_write(32'h4, 32'hFFFF_FFFF, 1);
      wb_write(32'h14, 32'h0000_0000, 1);
      wb_read(32'h8, 32'h0, "clear_reads0", 1);
      wb_read(32'h0, ctrl_readback(32'h0001_000F), "ctrl_kept", 1);
      check_all("unmapped");

      // reset in the middle of a hold aborts it
      wb_write(32'h8, 32'h4, 1);
      repeat (5) tick();
      reset = 1;
      tick();
      chk("rst_hold_latch", 32'(latch_o), 0);
      chk("rst_hold_ack", 32'(ack), 0);
      reset = 0;
      m_reset();
      write_ctrl(32'h4);
      pulse_vec(4'b0100);
      repeat (RESET_SHR + 4) tick();
      check_all("rst_hold");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
